// File: rtl/ysyx_22040729_pkg.sv
// Shared sizes and the writeback request payload for the regfile writeback controller.
package ysyx_22040729_pkg;

    localparam int unsigned REGI_DEPTH = 32;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned CNT_WIDTH  = 2;
    localparam int unsigned AW         = $clog2(REGI_DEPTH);

    typedef struct packed {
        logic                  valid;
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/ysyx_22040729_rr_arb2.sv
// Two-way round-robin arbiter; the preference flips to the loser after every conflict.
module ysyx_22040729_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr = 0 prefers req[0], ptr = 1 prefers req[1]
    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (req == 2'b11) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/ysyx_22040729_regfile_wb_ctrl.sv
// Arbitrates EXU/LSU writeback onto the single RF write port and tracks
// per-register pending writes so decode can stall on RAW hazards.
module ysyx_22040729_regfile_wb_ctrl
    import ysyx_22040729_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic                  issue_ready,
    input  logic                  req0_valid,
    input  logic [AW-1:0]         req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [AW-1:0]         req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_wen,
    output logic [AW-1:0]         rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [AW-1:0]         raddr1,
    input  logic [AW-1:0]         raddr2,
    output logic                  busy1,
    output logic                  busy2
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    wb_req_t req0;
    wb_req_t req1;
    wb_req_t win;
    logic [1:0] gnt;
    logic       grant_any;

    logic [CNT_WIDTH-1:0]  cnt [REGI_DEPTH];
    logic [REGI_DEPTH-1:0] inc_vec;
    logic [REGI_DEPTH-1:0] dec_vec;

    always_comb begin
        req0.valid = req0_valid;
        req0.addr  = req0_addr;
        req0.data  = req0_data;
        req1.valid = req1_valid;
        req1.addr  = req1_addr;
        req1.data  = req1_data;
    end

    ysyx_22040729_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1.valid, req0.valid}),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign grant_any  = |gnt;
    assign win        = gnt[1] ? req1 : req0;

    // Write stage: x0 grants complete the handshake but never assert rf_wen
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= grant_any && (win.addr != '0);
            if (grant_any) begin
                rf_waddr <= win.addr;
                rf_wdata <= win.data;
            end
        end
    end

    assign issue_ready = (issue_rd == '0) || (cnt[issue_rd] != CNT_MAX);
    assign busy1       = (raddr1 != '0) && (cnt[raddr1] != '0);
    assign busy2       = (raddr2 != '0) && (cnt[raddr2] != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            inc_vec[issue_rd] = 1'b1;
        end
        if (rf_wen) begin
            dec_vec[rf_waddr] = 1'b1;
        end
    end

    // Pending-write counters; a simultaneous issue and commit cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REGI_DEPTH; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < REGI_DEPTH; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + CNT_WIDTH'(1);
                end else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - CNT_WIDTH'(1);
                end
            end
        end
    end

    // A commit with no outstanding issue indicates a protocol error upstream
    always_ff @(posedge clk) begin
        if (!rst && rf_wen && !inc_vec[rf_waddr]) begin
            assert (cnt[rf_waddr] != '0)
            else $error("scoreboard underflow on x%0d", rf_waddr);
        end
    end

endmodule

// File: tb/tb_ysyx_22040729_regfile_wb_ctrl.sv
// Directed bench: expected RF writes go into a queue checked by a separate monitor.
module tb_ysyx_22040729_regfile_wb_ctrl;
    import ysyx_22040729_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  issue_valid;
    logic [AW-1:0]         issue_rd;
    logic                  issue_ready;
    logic                  req0_valid;
    logic [AW-1:0]         req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [AW-1:0]         req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    logic                  rf_wen;
    logic [AW-1:0]         rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [AW-1:0]         raddr1;
    logic [AW-1:0]         raddr2;
    logic                  busy1;
    logic                  busy2;

    typedef struct packed {
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    wr_t exp_q [$];
    int  n_cmp = 0;
    int  n_err = 0;

    ysyx_22040729_regfile_wb_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .busy1       (busy1),
        .busy2       (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DATA_WIDTH-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Drive on the falling edge, then let comb outputs settle before checking
    task automatic step();
        @(negedge clk);
    endtask

    // Monitor: every RF write must match the next expected write
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rf_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rf_write: got unexpected write x%0d=%h, required none", rf_waddr, rf_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
                    chk("rf_wdata", rf_wdata, e.data);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_rd = '0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        raddr1 = 5'd5; raddr2 = 5'd3;
        step(); step();
        rst = 1'b0;
        #1;
        // 1: reset state
        chk("rst_rf_wen", 64'(rf_wen), 64'd0);
        chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_rf_wdata", rf_wdata, 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        chk("rst_busy2", 64'(busy2), 64'd0);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_req0_ready", 64'(req0_ready), 64'd0);
        chk("rst_req1_ready", 64'(req1_ready), 64'd0);

        // 2: single EXU writeback to x5
        step(); issue_valid = 1'b1; issue_rd = 5'd5; #1;
        chk("t2_issue_ready", 64'(issue_ready), 64'd1);
        step(); issue_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'hABCD; push(5'd5, 64'hABCD); #1;
        chk("t2_busy_N", 64'(busy1), 64'd1);
        chk("t2_req0_ready", 64'(req0_ready), 64'd1);
        chk("t2_req1_ready", 64'(req1_ready), 64'd0);
        step(); req0_valid = 1'b0; #1;
        chk("t2_busy_N1", 64'(busy1), 64'd1);
        step(); #1;
        chk("t2_busy_N2", 64'(busy1), 64'd0);

        // 3: EXU and LSU conflict for three cycles
        raddr1 = 5'd3; raddr2 = 5'd4;
        step(); issue_valid = 1'b1; issue_rd = 5'd3;
        step(); issue_rd = 5'd3;
        step(); issue_rd = 5'd4;
        step(); issue_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'h111;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 64'h222;
        push(5'd3, 64'h111); #1;
        chk("t3_c1_req0_ready", 64'(req0_ready), 64'd1);
        chk("t3_c1_req1_ready", 64'(req1_ready), 64'd0);
        step(); req0_data = 64'h333; push(5'd4, 64'h222); #1;
        chk("t3_c2_req0_ready", 64'(req0_ready), 64'd0);
        chk("t3_c2_req1_ready", 64'(req1_ready), 64'd1);
        step(); req1_valid = 1'b0; push(5'd3, 64'h333); #1;
        chk("t3_c3_req0_ready", 64'(req0_ready), 64'd1);
        chk("t3_busy3", 64'(busy1), 64'd1);
        step(); req0_valid = 1'b0;
        step(); step(); #1;
        chk("t3_busy3_clear", 64'(busy1), 64'd0);
        chk("t3_busy4_clear", 64'(busy2), 64'd0);

        // 4: counter saturation on x7
        for (int i = 0; i < 3; i++) begin
            step(); issue_valid = 1'b1; issue_rd = 5'd7; #1;
            chk($sformatf("t4_issue%0d_ready", i), 64'(issue_ready), 64'd1);
        end
        step(); #1;
        chk("t4_saturated", 64'(issue_ready), 64'd0);
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 64'h777; push(5'd7, 64'h777); #1;
        chk("t4_req0_ready", 64'(req0_ready), 64'd1);
        step(); req0_valid = 1'b0; #1;
        chk("t4_same_cycle_dec", 64'(issue_ready), 64'd0);
        step(); #1;
        chk("t4_after_dec", 64'(issue_ready), 64'd1);
        step(); issue_valid = 1'b0;

        // 5: x0 writeback
        raddr1 = '0;
        req1_valid = 1'b1; req1_addr = '0; req1_data = 64'hFF; #1;
        chk("t5_req1_ready", 64'(req1_ready), 64'd1);
        chk("t5_busy_x0", 64'(busy1), 64'd0);
        issue_valid = 1'b1; issue_rd = '0; #1;
        chk("t5_issue_ready_x0", 64'(issue_ready), 64'd1);
        step(); req1_valid = 1'b0; issue_valid = 1'b0; #1;
        chk("t5_rf_wen", 64'(rf_wen), 64'd0);
        chk("t5_busy_x0_after", 64'(busy1), 64'd0);

        // 6: same-edge issue and commit on x9, then mid-stream reset
        raddr1 = 5'd9; raddr2 = 5'd7;
        step(); issue_valid = 1'b1; issue_rd = 5'd9;
        step(); issue_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 64'h99; push(5'd9, 64'h99);
        step(); req0_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9; #1;
        chk("t6_rf_wen_x9", 64'(rf_wen), 64'd1);
        chk("t6_issue_ready", 64'(issue_ready), 64'd1);
        step(); issue_valid = 1'b0; #1;
        chk("t6_busy9", 64'(busy1), 64'd1);
        chk("t6_busy7", 64'(busy2), 64'd1);
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'h5;
        step(); rst = 1'b0; req0_valid = 1'b0; #1;
        chk("t6_rst_busy1", 64'(busy1), 64'd0);
        chk("t6_rst_busy2", 64'(busy2), 64'd0);
        chk("t6_rst_rf_wen", 64'(rf_wen), 64'd0);

        step(); step(); #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
